// File: rtl/sysctl_gen2.sv
// sysctl_gen2 -- system controller CSR bank.
//   GPIO input synchronizer with change interrupt, GPIO output register,
//   two identical 32-bit compare timers and a small scratch register file,
//   all reachable through a single-cycle-latency CSR port.
// Ports:
//   sys_clk       sole clock, rising edge
//   sys_rst       asynchronous active-high reset
//   csr_a[13:0]   CSR address: [13:10] bank select, [4:0] register
//   csr_we        CSR write strobe
//   csr_di[31:0]  CSR write data
//   csr_do[31:0]  registered CSR read data (one cycle after address)
//   gpio_inputs   asynchronous external inputs
//   gpio_outputs  registered GPIO outputs
//   gpio_irq      one-cycle pulse on an enabled input change
//   timer0_irq    timer 0 expiry pulse
//   timer1_irq    timer 1 expiry pulse
module sysctl_gen2 #(
   parameter logic [3:0]  csr_addr = 4'h0,
   parameter int unsigned ninputs  = 8,
   parameter int unsigned noutputs = 8,
   parameter int unsigned nscratch = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [13:0]         csr_a,
   input  logic                csr_we,
   input  logic [31:0]         csr_di,
   output logic [31:0]         csr_do,
   input  logic [ninputs-1:0]  gpio_inputs,
   output logic [noutputs-1:0] gpio_outputs,
   output logic                gpio_irq,
   output logic                timer0_irq,
   output logic                timer1_irq
);

   localparam logic [4:0] A_GPIO_IN    = 5'd0;
   localparam logic [4:0] A_GPIO_OUT   = 5'd1;
   localparam logic [4:0] A_GPIO_IRQEN = 5'd2;
   localparam logic [4:0] A_T0_CTRL    = 5'd4;
   localparam logic [4:0] A_T0_CMP     = 5'd5;
   localparam logic [4:0] A_T0_CNT     = 5'd6;
   localparam logic [4:0] A_T1_CTRL    = 5'd8;
   localparam logic [4:0] A_T1_CMP     = 5'd9;
   localparam logic [4:0] A_T1_CNT     = 5'd10;
   localparam int unsigned SCRATCH_BASE = 20;

   logic [ninputs-1:0]  r_sync1, r_sync2, r_sync3;
   logic [ninputs-1:0]  r_irqen;
   logic [noutputs-1:0] r_gpio_out;
   logic                r_gpio_irq;
   logic [1:0]          r_ctrl [2];   // bit0 EN, bit1 AR
   logic [31:0]         r_cmp  [2];
   logic [31:0]         r_cnt  [2];
   logic [1:0]          r_tirq;
   logic [31:0]         r_scratch [nscratch];
   logic [31:0]         r_csr_do;

   logic        w_sel;
   logic        w_wr;
   logic [4:0]  w_reg;
   logic [31:0] w_rdata;
   logic [1:0]  w_expire;
   logic        w_unused;

   assign w_sel    = (csr_a[13:10] == csr_addr);
   assign w_wr     = csr_we & w_sel;
   assign w_reg    = csr_a[4:0];
   assign w_unused = &{1'b0, csr_a[9:5]};

   always_comb begin
      for (int unsigned t = 0; t < 2; t++)
         w_expire[t] = r_ctrl[t][0] && (r_cnt[t] == r_cmp[t]);
   end

   // Read mux sees the pre-edge register values, so a read that coincides
   // with a write to the same register returns the old contents.
   always_comb begin
      w_rdata = '0;
      case (w_reg)
         A_GPIO_IN:    w_rdata[ninputs-1:0]  = r_sync2;
         A_GPIO_OUT:   w_rdata[noutputs-1:0] = r_gpio_out;
         A_GPIO_IRQEN: w_rdata[ninputs-1:0]  = r_irqen;
         A_T0_CTRL:    w_rdata[1:0]          = r_ctrl[0];
         A_T0_CMP:     w_rdata               = r_cmp[0];
         A_T0_CNT:     w_rdata               = r_cnt[0];
         A_T1_CTRL:    w_rdata[1:0]          = r_ctrl[1];
         A_T1_CMP:     w_rdata               = r_cmp[1];
         A_T1_CNT:     w_rdata               = r_cnt[1];
         default:      ;
      endcase
      for (int unsigned i = 0; i < nscratch; i++)
         if (w_reg == 5'(SCRATCH_BASE + i)) w_rdata = r_scratch[i];
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_csr_do   <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_sync3    <= '0;
         r_irqen    <= '0;
         r_gpio_out <= '0;
         r_gpio_irq <= 1'b0;
      end else begin
         r_csr_do   <= w_sel ? w_rdata : '0;
         r_sync1    <= gpio_inputs;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_gpio_irq <= |((r_sync2 ^ r_sync3) & r_irqen);
         if (w_wr && w_reg == A_GPIO_OUT)   r_gpio_out <= csr_di[noutputs-1:0];
         if (w_wr && w_reg == A_GPIO_IRQEN) r_irqen    <= csr_di[ninputs-1:0];
      end
   end

   // Timer t occupies CTRL/CMP/CNT at 4+4t, 5+4t, 6+4t. CSR writes to CTRL
   // and CNT override the automatic EN clear, reload and increment.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int unsigned t = 0; t < 2; t++) begin
            r_ctrl[t] <= '0;
            r_cmp[t]  <= '0;
            r_cnt[t]  <= '0;
         end
         r_tirq <= '0;
      end else begin
         for (int unsigned t = 0; t < 2; t++) begin
            if (w_wr && w_reg == 5'(4 + 4 * t))
               r_ctrl[t] <= csr_di[1:0];
            else if (w_expire[t] && !r_ctrl[t][1])
               r_ctrl[t][0] <= 1'b0;

            if (w_wr && w_reg == 5'(5 + 4 * t))
               r_cmp[t] <= csr_di;

            if (w_wr && w_reg == 5'(6 + 4 * t))
               r_cnt[t] <= csr_di;
            else if (w_expire[t])
               r_cnt[t] <= '0;
            else if (r_ctrl[t][0])
               r_cnt[t] <= r_cnt[t] + 32'd1;

            r_tirq[t] <= w_expire[t];
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int unsigned i = 0; i < nscratch; i++)
            r_scratch[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < nscratch; i++)
            if (w_wr && w_reg == 5'(SCRATCH_BASE + i)) r_scratch[i] <= csr_di;
      end
   end

   assign csr_do       = r_csr_do;
   assign gpio_outputs = r_gpio_out;
   assign gpio_irq     = r_gpio_irq;
   assign timer0_irq   = r_tirq[0];
   assign timer1_irq   = r_tirq[1];

endmodule

// File: tb/tb_sysctl_gen2.sv
// tb_sysctl_gen2 -- self-checking bench for sysctl_gen2 (default parameters).
//   Read expectations are queued when an access is driven and popped when
//   csr_do / irq outputs are sampled one edge later.
module tb_sysctl_gen2;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;
   logic [7:0]  gpio_inputs;
   logic [7:0]  gpio_outputs;
   logic        gpio_irq;
   logic        timer0_irq;
   logic        timer1_irq;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic        irq_q [$];

   // timer reference model
   logic [31:0] m_cnt [2];
   logic [31:0] m_cmp [2];
   logic        m_en  [2];
   logic        m_ar  [2];
   int          n_t1_pulses;

   sysctl_gen2 #(
      .csr_addr (4'h0),
      .ninputs  (8),
      .noutputs (8),
      .nscratch (4)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .csr_a        (csr_a),
      .csr_we       (csr_we),
      .csr_di       (csr_di),
      .csr_do       (csr_do),
      .gpio_inputs  (gpio_inputs),
      .gpio_outputs (gpio_outputs),
      .gpio_irq     (gpio_irq),
      .timer0_irq   (timer0_irq),
      .timer1_irq   (timer1_irq)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [13:0] A(input logic [3:0] bank, input logic [4:0] r);
      return {bank, 5'b00000, r};
   endfunction

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      cyc();
      csr_we = 1'b0;
   endtask

   task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string tag);
      csr_a  = a;
      csr_we = 1'b0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      cyc();
      chk(tag_q.pop_front(), csr_do, exp_q.pop_front());
   endtask

   // One cycle with T_CNT of timer t on the address bus (optionally written),
   // checking the read data and the timer's irq against the model.
   task automatic step_tmr(input int t, input bit wr, input logic [31:0] wval);
      logic expire;
      csr_a  = A(4'h0, (t == 0) ? 5'd6 : 5'd10);
      csr_we = wr;
      csr_di = wval;
      expire = m_en[t] && (m_cnt[t] == m_cmp[t]);
      exp_q.push_back(m_cnt[t]);
      irq_q.push_back(expire);
      if (wr)             m_cnt[t] = wval;
      else if (expire)    m_cnt[t] = 32'd0;
      else if (m_en[t])   m_cnt[t] = m_cnt[t] + 32'd1;
      if (expire && !m_ar[t]) m_en[t] = 1'b0;
      cyc();
      csr_we = 1'b0;
      if (t == 0) begin
         chk("t0_cnt", csr_do, exp_q.pop_front());
         chk("t0_irq", {31'd0, timer0_irq}, {31'd0, irq_q.pop_front()});
      end else begin
         if (timer1_irq) n_t1_pulses++;
         chk("t1_cnt", csr_do, exp_q.pop_front());
         chk("t1_irq", {31'd0, timer1_irq}, {31'd0, irq_q.pop_front()});
      end
   endtask

   initial begin
      sys_rst     = 1'b1;
      csr_a       = '0;
      csr_we      = 1'b0;
      csr_di      = '0;
      gpio_inputs = '0;
      n_t1_pulses = 0;
      for (int t = 0; t < 2; t++) begin
         m_cnt[t] = 0; m_cmp[t] = 0; m_en[t] = 0; m_ar[t] = 0;
      end
      cyc(); cyc();
      chk("rst_csr_do", csr_do, 32'd0);
      chk("rst_gpio_out", {24'd0, gpio_outputs}, 32'd0);
      chk("rst_irqs", {29'd0, gpio_irq, timer0_irq, timer1_irq}, 32'd0);
      #2 sys_rst = 1'b0;
      cyc();

      // scratch storage, unmapped addresses, bank select
      for (int i = 0; i < 4; i++) csr_write(A(4'h0, 5'(20 + i)), 32'hDEADBEEF + 32'(i));
      for (int i = 0; i < 4; i++) rd(A(4'h0, 5'(20 + i)), 32'hDEADBEEF + 32'(i), "scratch_rd");
      rd(A(4'h0, 5'd3), 32'd0, "unmapped_3");
      rd(A(4'h0, 5'd31), 32'd0, "unmapped_31");
      csr_write(A(4'h1, 5'd20), 32'h0);
      rd(A(4'h0, 5'd20), 32'hDEADBEEF, "bank_mismatch_wr");
      rd(A(4'h1, 5'd20), 32'd0, "bank_mismatch_rd");

      // read-and-write to the same register returns the old value
      csr_a  = A(4'h0, 5'd21);
      csr_di = 32'h12345678;
      csr_we = 1'b1;
      exp_q.push_back(32'hDEADBEF0);
      tag_q.push_back("rw_same_cycle");
      cyc();
      csr_we = 1'b0;
      chk(tag_q.pop_front(), csr_do, exp_q.pop_front());
      rd(A(4'h0, 5'd21), 32'h12345678, "rw_new_value");

      // timer 0: auto-restart, period CMP+1
      csr_write(A(4'h0, 5'd5), 32'd4);
      csr_write(A(4'h0, 5'd4), 32'd3);
      m_cmp[0] = 4; m_en[0] = 1; m_ar[0] = 1; m_cnt[0] = 0;
      rd(A(4'h0, 5'd4), 32'd3, "t0_ctrl");
      m_cnt[0] = 1;  // the CTRL read cycle advanced the counter once
      for (int k = 0; k < 12; k++) step_tmr(0, 1'b0, 32'd0);
      // CNT write coinciding with expiry: pulse fires, written value wins
      for (int k = 0; k < 6 && m_cnt[0] != 32'd4; k++) step_tmr(0, 1'b0, 32'd0);
      chk("t0_sync", m_cnt[0], 32'd4);
      step_tmr(0, 1'b1, 32'd100);
      step_tmr(0, 1'b0, 32'd0);
      step_tmr(0, 1'b0, 32'd0);
      csr_write(A(4'h0, 5'd4), 32'd0);
      m_en[0] = 0;

      // timer 1: one-shot
      csr_write(A(4'h0, 5'd9), 32'd2);
      csr_write(A(4'h0, 5'd8), 32'd1);
      m_cmp[1] = 2; m_en[1] = 1; m_ar[1] = 0; m_cnt[1] = 0;
      for (int k = 0; k < 8; k++) step_tmr(1, 1'b0, 32'd0);
      chk("t1_pulse_count", n_t1_pulses, 32'd1);
      rd(A(4'h0, 5'd8), 32'd0, "t1_ctrl_cleared");

      // timer 1: CMP=0 with auto-restart holds irq high
      csr_write(A(4'h0, 5'd9), 32'd0);
      csr_write(A(4'h0, 5'd8), 32'd3);
      m_cmp[1] = 0; m_en[1] = 1; m_ar[1] = 1; m_cnt[1] = 0;
      for (int k = 0; k < 4; k++) step_tmr(1, 1'b0, 32'd0);
      csr_write(A(4'h0, 5'd8), 32'd0);

      // GPIO change interrupt, enabled on bit 0 only
      csr_write(A(4'h0, 5'd2), 32'h01);
      cyc();
      gpio_inputs[0] = 1'b1;
      cyc(); chk("girq_e1", {31'd0, gpio_irq}, 32'd0);
      cyc(); chk("girq_e2", {31'd0, gpio_irq}, 32'd0);
      cyc(); chk("girq_e3", {31'd0, gpio_irq}, 32'd1);
      cyc(); chk("girq_e4", {31'd0, gpio_irq}, 32'd0);
      gpio_inputs[1] = 1'b1;
      begin
         int pulses = 0;
         for (int k = 0; k < 6; k++) begin
            cyc();
            if (gpio_irq) pulses++;
         end
         chk("girq_bit1_masked", pulses, 32'd0);
      end
      rd(A(4'h0, 5'd0), 32'h03, "gpio_in");

      // GPIO_OUT, then reset in the middle of a timer count
      csr_write(A(4'h0, 5'd1), 32'hA5);
      chk("gpio_out_pins", {24'd0, gpio_outputs}, 32'hA5);
      rd(A(4'h0, 5'd1), 32'hA5, "gpio_out_rd");
      gpio_inputs = '0;
      csr_write(A(4'h0, 5'd5), 32'd100);
      csr_write(A(4'h0, 5'd4), 32'd1);
      for (int k = 0; k < 6; k++) cyc();
      #2 sys_rst = 1'b1;
      #1;
      chk("async_rst_gpio_out", {24'd0, gpio_outputs}, 32'd0);
      chk("async_rst_csr_do", csr_do, 32'd0);
      cyc(); cyc();
      #2 sys_rst = 1'b0;
      begin
         logic [4:0] regs [13] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8,
                                   5'd9, 5'd10, 5'd20, 5'd21, 5'd22, 5'd23};
         for (int k = 0; k < 13; k++) rd(A(4'h0, regs[k]), 32'd0, "post_rst_reg");
      end
      chk("post_rst_irqs", {29'd0, gpio_irq, timer0_irq, timer1_irq}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sysctl_gen2.md
SYSCTL_GEN2 -- requirements
Module: sysctl_gen2

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0: CSR bank select compared against csr_a[13:10].
REQ-002 SHALL have parameter ninputs, default 8: GPIO input width, 1..32.
REQ-003 SHALL have parameter noutputs, default 8: GPIO output width, 1..32.
REQ-004 SHALL have parameter nscratch, default 4: number of 32-bit scratch registers, 1..8.
REQ-005 SHALL have port sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port csr_a  input  14  CSR address; csr_a[4:0] selects the register.
REQ-008 SHALL have port csr_we  input  1  CSR write strobe.
REQ-009 SHALL have port csr_di  input  32  CSR write data.
REQ-010 SHALL have port csr_do  output  32  CSR read data, registered.
REQ-011 SHALL have port gpio_inputs  input  ninputs  asynchronous external inputs.
REQ-012 SHALL have port gpio_outputs  output  noutputs  registered GPIO outputs.
REQ-013 SHALL have port gpio_irq  output  1  input-change interrupt pulse.
REQ-014 SHALL have port timer0_irq  output  1  timer 0 expiry pulse.
REQ-015 SHALL have port timer1_irq  output  1  timer 1 expiry pulse.

Function
REQ-016 SHALL treat the bank as selected when csr_a[13:10]==csr_addr; otherwise ignore writes and drive csr_do=0 on the next edge.
REQ-017 SHALL use this map for csr_a[4:0]: 0 GPIO_IN (RO), 1 GPIO_OUT, 2 GPIO_IRQEN, 4/5/6 T0_CTRL/T0_CMP/T0_CNT, 8/9/10 T1_CTRL/T1_CMP/T1_CNT, 20..20+nscratch-1 SCRATCH[i]; all other addresses read 0 and ignore writes.
REQ-018 SHALL present read data on csr_do exactly one cycle after the address (1-cycle latency); unused upper bits read 0.
REQ-019 SHALL return the pre-write value on a read-and-write to the same register in the same cycle.
REQ-020 SHALL pass gpio_inputs through a 2-flop synchronizer; GPIO_IN returns the second stage.
REQ-021 SHALL pulse gpio_irq high for exactly one cycle when (sync2 XOR sync3) AND GPIO_IRQEN[ninputs-1:0] is nonzero, sync3 being sync2 delayed one cycle.
REQ-022 SHALL drive gpio_outputs directly from GPIO_OUT[noutputs-1:0].
REQ-023 T_CTRL SHALL hold bit0 EN and bit1 AR (auto-restart); other bits read 0.
REQ-024 While EN=1, each timer SHALL increment CNT by 1 per cycle, 32-bit, wrapping 0xFFFFFFFF->0.
REQ-025 When EN=1 and CNT==CMP, a timer SHALL, on that edge, set CNT to 0, pulse its irq for one cycle, and clear EN if AR=0 (one-shot); period = CMP+1 cycles.
REQ-026 While EN=0, CNT SHALL hold and irq SHALL stay 0.
REQ-027 A CSR write to T_CNT or T_CTRL SHALL take precedence over increment, expiry reload and EN auto-clear in the same cycle; the expiry irq pulse still fires.
REQ-028 CMP=0 with EN=1, AR=1 SHALL expire every cycle (irq held high).
REQ-029 The two timers SHALL be independent and identical.
REQ-030 SCRATCH registers SHALL be plain 32-bit read/write storage.

Reset
REQ-031 On sys_rst high, asynchronously: csr_do=0, GPIO_OUT=0, GPIO_IRQEN=0, all T_CTRL/T_CMP/T_CNT=0, all SCRATCH=0, synchronizer stages=0, all irq outputs=0.
REQ-032 Reset asserted mid-count SHALL abort the timer with no irq pulse; no irq pulse SHALL be generated on reset release even if inputs are nonzero at that time... except the normal change pulse 3 cycles later if sync2 then differs from sync3.

Verification
REQ-033 Write SCRATCH[0..3]=0xDEADBEEF+i, read back -> exact values one cycle after address; read addr 3 -> 0; csr_addr mismatch write -> no change.
REQ-034 T0_CMP=4, T0_CTRL=3 -> timer0_irq pulses every 5 cycles, CNT sequence 0,1,2,3,4,0.
REQ-035 T1_CMP=2, T1_CTRL=1 -> single timer1_irq pulse, T1_CTRL reads 0 afterwards, CNT reads 0 and holds.
REQ-036 GPIO_IRQEN=0x01, toggle gpio_inputs[0] then [1] -> exactly one gpio_irq pulse 3 cycles after the bit-0 edge, none for bit 1; GPIO_IN reflects both.
REQ-037 Write T0_CNT=100 in the same cycle as an expiry -> irq pulses, CNT=100 next cycle.
REQ-038 Assert sys_rst mid-count with GPIO_OUT=0xA5 -> gpio_outputs=0 immediately (no clock edge), all registers read 0 after release.
